// File: rtl/pacman_pkg.sv
// Shared definitions for the player-motion path: direction codes, FSM encoding
// and default spawn point, also used by collision_detection and the renderer.
package pacman_pkg;

    localparam logic [3:0] DIR_LEFT  = 4'b1000;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0001;

    localparam logic [8:0] START_X_DEF = 9'd160;
    localparam logic [8:0] START_Y_DEF = 9'd232;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROBE_Q = 2'd1,
        ST_PROBE_F = 2'd2,
        ST_MOVE    = 2'd3
    } motion_state_t;

    function automatic logic dir_valid(input logic [3:0] d);
        return (d == DIR_LEFT) || (d == DIR_UP) || (d == DIR_RIGHT) || (d == DIR_DOWN);
    endfunction

endpackage

// File: rtl/pacman_motion.sv
// Player movement controller: probes the buffered turn, falls back to the
// current heading, and commits one SPEED-pixel step per successful tick.
module pacman_motion
    import pacman_pkg::*;
#(
    parameter logic [8:0] START_X = START_X_DEF,
    parameter logic [8:0] START_Y = START_Y_DEF,
    parameter int         SPEED   = 2,
    parameter int         SETTLE  = 2,
    parameter logic [8:0] X_LO    = 9'd4,
    parameter logic [8:0] X_HI    = 9'd316
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] key_dir,
    input  logic       collide,
    output logic [3:0] probe_dir,
    output logic [8:0] p_x,
    output logic [8:0] p_y,
    output logic [3:0] facing,
    output logic       moving,
    output logic       busy
);

    localparam logic [8:0] STEP        = 9'(SPEED);
    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 1);

    motion_state_t state_q, state_d;
    logic [3:0]    queued_q, queued_d;
    logic [3:0]    facing_q, facing_d;
    logic [3:0]    probe_q, probe_d;
    logic [8:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic          moving_q, moving_d;
    logic          pending_q, pending_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          settled;

    assign settled = (cnt_q == SETTLE_LAST);

    always_comb begin
        state_d   = state_q;
        queued_d  = queued_q;
        facing_d  = facing_q;
        probe_d   = probe_q;
        x_d       = x_q;
        y_d       = y_q;
        moving_d  = moving_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;

        if (dir_valid(key_dir)) begin
            queued_d = key_dir;
        end
        if (state_q != ST_IDLE && tick) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick || pending_q) begin
                    pending_d = 1'b0;
                    probe_d   = queued_q;
                    cnt_d     = 2'd0;
                    state_d   = ST_PROBE_Q;
                end
            end
            ST_PROBE_Q: begin
                // probe_q holds the queued direction as it was when probed, so a
                // key change during the settle window cannot commit an unchecked turn
                if (!settled) begin
                    cnt_d = cnt_q + 2'd1;
                end else if (!collide) begin
                    facing_d = probe_q;
                    state_d  = ST_MOVE;
                end else if (probe_q == facing_q) begin
                    moving_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    probe_d = facing_q;
                    cnt_d   = 2'd0;
                    state_d = ST_PROBE_F;
                end
            end
            ST_PROBE_F: begin
                if (!settled) begin
                    cnt_d = cnt_q + 2'd1;
                end else if (!collide) begin
                    state_d = ST_MOVE;
                end else begin
                    moving_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_MOVE: begin
                case (facing_q)
                    DIR_LEFT:  x_d = (x_q < X_LO + STEP) ? X_HI : x_q - STEP;
                    DIR_RIGHT: x_d = (9'(x_q + STEP) > X_HI) ? X_LO : x_q + STEP;
                    DIR_UP:    y_d = y_q - STEP;
                    DIR_DOWN:  y_d = y_q + STEP;
                    default:   ;
                endcase
                moving_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            queued_q  <= DIR_LEFT;
            facing_q  <= DIR_LEFT;
            probe_q   <= DIR_LEFT;
            x_q       <= START_X;
            y_q       <= START_Y;
            moving_q  <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            queued_q  <= queued_d;
            facing_q  <= facing_d;
            probe_q   <= probe_d;
            x_q       <= x_d;
            y_q       <= y_d;
            moving_q  <= moving_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign probe_dir = probe_q;
    assign p_x       = x_q;
    assign p_y       = y_q;
    assign facing    = facing_q;
    assign moving    = moving_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion with a registered map-probe model standing
// in for collision_detection; expected moves flow through a scoreboard queue.
module tb_pacman_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] key_dir = 4'b0000;
    logic       collide = 1'b0;
    logic [3:0] probe_dir;
    logic [8:0] p_x;
    logic [8:0] p_y;
    logic [3:0] facing;
    logic       moving;
    logic       busy;

    logic [3:0] blocked_mask = 4'b0000;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [3:0] f;
        logic       m;
        logic [3:0] p;
        logic [7:0] done;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // One register stage like the real checker, so the sample must wait SETTLE cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) collide <= 1'b0;
        else     collide <= |(probe_dir & blocked_mask);
    end

    pacman_motion dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .key_dir  (key_dir),
        .collide  (collide),
        .probe_dir(probe_dir),
        .p_x      (p_x),
        .p_y      (p_y),
        .facing   (facing),
        .moving   (moving),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_key(input logic [3:0] k);
        @(negedge clk);
        key_dir = k;
        @(negedge clk);
        key_dir = 4'b0000;
    endtask

    // Push the expected outcome, pulse tick, watch until IDLE, then pop and compare.
    task automatic do_tick(input string tag, input int done_e, input logic [8:0] ex,
                           input logic [8:0] ey, input logic [3:0] ef, input logic em,
                           input logic [3:0] ep);
        exp_t       e;
        logic [8:0] x0, y0;
        logic [3:0] p1;
        logic       held;
        int         n;
        e.x = ex; e.y = ey; e.f = ef; e.m = em; e.p = ep; e.done = 8'(done_e);
        sb.push_back(e);
        x0 = p_x; y0 = p_y; p1 = 4'b0000; held = 1'b1; n = 0;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) p1 = probe_dir;
            if (k < done_e && (p_x !== x0 || p_y !== y0)) held = 1'b0;
            if (!busy) begin
                n = k;
                break;
            end
        end
        e = sb.pop_front();
        check({tag, ".idle_edge"}, n, 32'(e.done));
        check({tag, ".held"}, held, 1);
        check({tag, ".p_x"}, p_x, e.x);
        check({tag, ".p_y"}, p_y, e.y);
        check({tag, ".facing"}, facing, e.f);
        check({tag, ".moving"}, moving, e.m);
        check({tag, ".probe"}, p1, e.p);
        $display("tick %s: idle_edge=%0d x=%0d y=%0d facing=%b moving=%b", tag, n, p_x, p_y, facing, moving);
    endtask

    initial begin
        logic [8:0] ex, y0, prev_y;
        int         moves;

        repeat (2) @(posedge clk);
        #1;
        check("reset.p_x", p_x, 160);
        check("reset.p_y", p_y, 232);
        check("reset.facing", facing, 4'b1000);
        check("reset.probe", probe_dir, 4'b1000);
        check("reset.moving", moving, 0);
        check("reset.busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        $display("reset released: x=%0d y=%0d facing=%b", p_x, p_y, facing);

        set_key(4'b0010);
        do_tick("corridor", 3, 162, 232, 4'b0010, 1'b1, 4'b0010);

        set_key(4'b1000);
        do_tick("turn_back", 3, 160, 232, 4'b1000, 1'b1, 4'b1000);

        set_key(4'b0100);
        blocked_mask = 4'b0100;
        do_tick("buffered_fallback", 5, 158, 232, 4'b1000, 1'b1, 4'b0100);
        blocked_mask = 4'b0000;
        do_tick("buffered_retry", 3, 158, 230, 4'b0100, 1'b1, 4'b0100);

        set_key(4'b1000);
        blocked_mask = 4'b1100;
        do_tick("dead_end", 4, 158, 230, 4'b0100, 1'b0, 4'b1000);

        set_key(4'b0100);
        blocked_mask = 4'b0000;
        do_tick("up_free", 3, 158, 228, 4'b0100, 1'b1, 4'b0100);
        blocked_mask = 4'b0100;
        do_tick("same_dir_blocked", 2, 158, 228, 4'b0100, 1'b0, 4'b0100);

        // Three back-to-back ticks with an invalid key: one runs, one pends, one is lost.
        blocked_mask = 4'b0000;
        @(negedge clk);
        key_dir = 4'b1100;
        y0 = p_y;
        prev_y = p_y;
        moves = 0;
        tick = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) tick = 1'b0;
            if (p_y !== prev_y) moves++;
            prev_y = p_y;
        end
        check("multi.moves", moves, 2);
        check("multi.p_y", p_y, 32'(y0 - 9'd4));
        check("multi.queued", probe_dir, 4'b0100);
        check("multi.facing", facing, 4'b0100);
        check("multi.busy", busy, 0);
        $display("tick multi: moves=%0d y=%0d probe=%b", moves, p_y, probe_dir);
        @(negedge clk);
        key_dir = 4'b0000;

        // Walk left to the tunnel edge and through it.
        set_key(4'b1000);
        ex = p_x;
        for (int i = 0; i < 78; i++) begin
            ex = (ex < 9'd6) ? 9'd316 : ex - 9'd2;
            do_tick("left_walk", 3, ex, 224, 4'b1000, 1'b1, 4'b1000);
        end
        check("wrap_left.p_x", p_x, 316);
        set_key(4'b0010);
        do_tick("wrap_right", 3, 4, 224, 4'b0010, 1'b1, 4'b0010);

        // Reset arriving while the fallback probe is in flight.
        set_key(4'b0100);
        blocked_mask = 4'b0100;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid.busy_before", busy, 1);
        check("rst_mid.probe_before", probe_dir, 4'b0010);
        #2 rst = 1'b1;
        #1;
        check("rst_mid.p_x", p_x, 160);
        check("rst_mid.p_y", p_y, 232);
        check("rst_mid.facing", facing, 4'b1000);
        check("rst_mid.probe", probe_dir, 4'b1000);
        check("rst_mid.moving", moving, 0);
        check("rst_mid.busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_after.p_x", p_x, 160);
        check("rst_after.p_y", p_y, 232);
        check("rst_after.moving", moving, 0);
        check("rst_after.busy", busy, 0);
        $display("reset mid-probe: x=%0d y=%0d busy=%b", p_x, p_y, busy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
